// File: rtl/pwm_pkg.sv
// Shared servo PWM definitions for the capture block and the servo generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    StArm,
    StWaitRise,
    StHigh,
    StLow
  } capture_state_e;

  localparam int unsigned CLK_PER_MS   = 100000;
  localparam int unsigned SERVO_PERIOD = 2000000;
  localparam int unsigned SERVO_MIN    = 100000;
  localparam int unsigned SERVO_MAX    = 200000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall pulses and a
// ready flag that rises once the synchroniser holds real pin samples.
module sync_edge_det (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  // Reset zeros in the chain must not be mistaken for a low pin level.
  assign ready = fill_q[1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high width and rising-to-rising period of an asynchronous PWM pin,
// producing one validated measurement per completed period.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MIN_HIGH = 50000,
  parameter int unsigned MAX_HIGH = 250000,
  parameter int unsigned TIMEOUT  = 4000000
) (
  input  logic             clk,
  input  logic             res,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             range_err,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMin      = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] CntMax      = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] CntTimeout  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntLastTick = CNT_W'(TIMEOUT - 1);

  logic pin_level, pin_rise, pin_fall, sync_ready;

  sync_edge_det u_sync (
    .clk   (clk),
    .res   (res),
    .din   (pwm_in),
    .level (pin_level),
    .rise  (pin_rise),
    .fall  (pin_fall),
    .ready (sync_ready)
  );

  capture_state_e   state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] h_tmp_q, h_tmp_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] p_inc;
  logic             p_expiring;

  assign p_inc      = (p_q >= CntTimeout) ? CntTimeout : p_q + CntOne;
  // The awaited edge takes priority when it lands on the last tick.
  assign p_expiring = (p_q >= CntLastTick);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    h_tmp_d  = h_tmp_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    lost_d   = lost_q;
    unique case (state_q)
      StArm: begin
        if (sync_ready && !pin_level) state_d = StWaitRise;
      end
      StWaitRise: begin
        if (pin_rise) begin
          p_d     = CntOne;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (pin_fall) begin
          h_tmp_d = p_q;
          p_d     = p_inc;
          state_d = StLow;
        end else if (p_expiring) begin
          lost_d  = 1'b1;
          p_d     = CntTimeout;
          state_d = StArm;
        end else begin
          p_d = p_inc;
        end
      end
      StLow: begin
        if (pin_rise) begin
          high_d   = h_tmp_q;
          period_d = p_q;
          valid_d  = 1'b1;
          err_d    = (h_tmp_q < CntMin) || (h_tmp_q > CntMax);
          lost_d   = 1'b0;
          p_d      = CntOne;
          state_d  = StHigh;
        end else if (p_expiring) begin
          lost_d  = 1'b1;
          p_d     = CntTimeout;
          state_d = StArm;
        end else begin
          p_d = p_inc;
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= StArm;
      p_q      <= '0;
      h_tmp_q  <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      h_tmp_q  <= h_tmp_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign range_err  = err_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: servo timings scaled down by SCALE,
// measurements predicted from pin-level edge times by a reference model.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int unsigned SCALE   = 2500;
  localparam int unsigned MIN_H   = 50000 / SCALE;        // 20
  localparam int unsigned MAX_H   = 250000 / SCALE;       // 100
  localparam int unsigned TO      = 1000;
  localparam int unsigned NOM_H   = SERVO_MAX / SCALE;    // 80
  localparam int unsigned NOM_P   = SERVO_PERIOD / SCALE; // 800
  localparam int unsigned SMIN_H  = SERVO_MIN / SCALE;    // 40
  // Pin driven at a negedge is seen by the measurement logic three posedges later.
  localparam int unsigned LATENCY = 3;

  logic        clk = 1'b0;
  logic        res;
  logic        pwm_in;
  logic [31:0] high_cnt, period_cnt;
  logic        valid, range_err, lost;

  pwm_capture #(
    .CNT_W    (32),
    .MIN_HIGH (MIN_H),
    .MAX_HIGH (MAX_H),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .res        (res),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .range_err  (range_err),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] h;
    logic [31:0] p;
    logic        e;
    logic        l;
    int unsigned c;
  } meas_t;

  meas_t exp_q[$];
  meas_t obs_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state, in pin-time (cycle of each driven edge).
  bit          ref_ok;
  bit          armed;
  int unsigned rise_t, fall_t;
  logic [31:0] last_h, last_p;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (res && valid) obs_q.push_back('{h: high_cnt, p: period_cnt, e: range_err, l: lost, c: cyc});
  end

  task automatic model_reset();
    ref_ok = 1'b0;
    armed  = (pwm_in == 1'b0);
  endtask

  task automatic model_edge(input logic lvl, input int unsigned t);
    logic [31:0] h, p;
    if (ref_ok && (t - rise_t) >= TO) ref_ok = 1'b0;
    if (!lvl) begin
      fall_t = t;
      armed  = 1'b1;
    end else begin
      if (ref_ok) begin
        h = fall_t - rise_t;
        p = t - rise_t;
        exp_q.push_back('{h: h, p: p, e: (h < MIN_H) || (h > MAX_H), l: 1'b0, c: t + LATENCY});
        last_h = h;
        last_p = p;
      end
      if (armed) begin
        ref_ok = 1'b1;
        rise_t = t;
      end
    end
  endtask

  // Caller sits on a negedge; level is held for n cycles.
  task automatic phase(input logic lvl, input int unsigned n);
    if (lvl != pwm_in) begin
      pwm_in = lvl;
      model_edge(lvl, cyc);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int unsigned h, input int unsigned per);
    phase(1'b1, h);
    phase(1'b0, per - h);
  endtask

  task automatic flush();
    meas_t e, o;
    repeat (LATENCY + 1) @(negedge clk);
    check_val("n_meas", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_val("high", o.h, e.h);
      check_val("period", o.p, e.p);
      check_val("range_err", {31'd0, o.e}, {31'd0, e.e});
      check_val("lost_at_valid", {31'd0, o.l}, {31'd0, e.l});
      check_val("valid_cycle", o.c, e.c);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_high"}, high_cnt, 0);
    check_val({tag, "_period"}, period_cnt, 0);
    check_val({tag, "_valid"}, {31'd0, valid}, 0);
    check_val({tag, "_err"}, {31'd0, range_err}, 0);
    check_val({tag, "_lost"}, {31'd0, lost}, 0);
  endtask

  // Asynchronous reset pulse a few ns into a low clock phase, held 3 cycles.
  task automatic mid_reset(input string tag);
    #2 res = 1'b0;
    #1 check_cleared(tag);
    repeat (3) @(negedge clk);
    res = 1'b1;
    model_reset();
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned h, l;
    int unsigned bnd_h[5];
    res    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    res = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);

    // Nominal servo frames.
    repeat (3) pulse(NOM_H, NOM_P);
    flush();
    check_val("nom_high", high_cnt, NOM_H);
    check_val("nom_period", period_cnt, NOM_P);
    check_val("nom_err", {31'd0, range_err}, 0);
    check_val("nom_lost", {31'd0, lost}, 0);

    // Minimum servo pulse, then an over-long one.
    repeat (2) pulse(SMIN_H, NOM_P);
    flush();
    check_val("min_high", high_cnt, SMIN_H);
    check_val("min_period", period_cnt, NOM_P);
    check_val("min_err", {31'd0, range_err}, 0);
    repeat (2) pulse(3 * SMIN_H, NOM_P);
    flush();
    check_val("over_high", high_cnt, 3 * SMIN_H);
    check_val("over_err", {31'd0, range_err}, 1);

    // Pin held high across reset release.
    phase(1'b1, 30);
    flush();
    mid_reset("hold_hi");
    phase(1'b1, 50);
    phase(1'b0, 700);
    repeat (2) pulse(NOM_H, NOM_P);
    flush();
    check_val("hold_hi_high", high_cnt, NOM_H);
    check_val("hold_hi_period", period_cnt, NOM_P);

    // Signal loss: last rise, then the pin stays low.
    pulse(NOM_H, NOM_P);
    phase(1'b1, NOM_H);
    phase(1'b0, 1);
    while (cyc < rise_t + TO + LATENCY - 2) @(negedge clk);
    check_val("lost_early", {31'd0, lost}, 0);
    @(negedge clk);
    check_val("lost_set", {31'd0, lost}, 1);
    repeat (100) @(negedge clk);
    check_val("lost_hold_high", high_cnt, last_h);
    check_val("lost_hold_period", period_cnt, last_p);
    flush();
    pulse(NOM_H, NOM_P);
    check_val("lost_kept", {31'd0, lost}, 1);
    repeat (2) pulse(NOM_H, NOM_P);
    flush();
    check_val("lost_cleared", {31'd0, lost}, 0);

    // Reset in the middle of a high phase.
    phase(1'b1, 20);
    flush();
    mid_reset("mid_hi");
    repeat (20) @(negedge clk);
    phase(1'b0, 700);
    repeat (2) pulse(NOM_H, NOM_P);
    flush();

    // Short pulses far below MIN_H.
    repeat (4) pulse(5, 20);
    flush();
    check_val("short_high", high_cnt, 5);
    check_val("short_period", period_cnt, 20);
    check_val("short_err", {31'd0, range_err}, 1);

    // Range limits and the longest period still accepted.
    bnd_h = '{MIN_H, MIN_H - 1, MAX_H, MAX_H + 1, 1};
    foreach (bnd_h[i]) pulse(bnd_h[i], 300);
    pulse(150, TO - 1);
    pulse(NOM_H, NOM_P);
    flush();

    // Random frames, all periods well inside the timeout.
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(1, 150);
      l = $urandom_range(1, 400);
      pulse(h, h + l);
    end
    phase(1'b0, 10);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming servo/RC-style PWM signal: high-pulse width and full period, both in clk cycles.
- Receive-side counterpart of the team's servo PWM generator. Used for loopback checking of generated servo pulses and for reading external PWM sources.
- Sits between an asynchronous pin and control logic; delivers one validated measurement per period.

Parameters:
- CNT_W, 32, width of all counters and measurement outputs.
- MIN_HIGH, 50000, smallest legal high width in cycles (0.5 ms at 100 MHz).
- MAX_HIGH, 250000, largest legal high width in cycles (2.5 ms).
- TIMEOUT, 4000000, cycles without an edge before the signal is declared lost (40 ms). Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- res  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- pwm_in  in  1  asynchronous PWM input.
- high_cnt  out  CNT_W  last measured high width in cycles.
- period_cnt  out  CNT_W  last measured period in cycles, rising edge to rising edge.
- valid  out  1  one-cycle strobe; high_cnt/period_cnt/range_err updated this cycle.
- range_err  out  1  last measurement had high_cnt < MIN_HIGH or high_cnt > MAX_HIGH.
- lost  out  1  level; no edge seen for TIMEOUT cycles.

Behaviour:
- Reset (res=0) clears all outputs, counters and synchroniser flops to 0, and forces state ARM. lost=0 after reset.
- Input path:
  - 2-flop synchroniser, then an edge detector comparing the synchronised level with a delayed copy.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge-to-detection latency is 2–3 cycles, identical for both edges, so widths are exact.
- Counter p, width CNT_W:
  - Loads 1 on a detected rise.
  - Otherwise increments each cycle in HIGH/LOW, saturating at TIMEOUT.
- State ARM: waits for sync level = 0, then goes to WAIT_RISE. This prevents a false rise when pwm_in is already high at reset release.
- State WAIT_RISE: on rise, p<=1 and go to HIGH. No measurement is produced; the first partial period is discarded.
- State HIGH: on fall, latch h_tmp<=p and go to LOW.
- State LOW: on rise, in a single cycle:
  - high_cnt<=h_tmp, period_cnt<=p, valid<=1.
  - range_err<=(h_tmp<MIN_HIGH)|(h_tmp>MAX_HIGH).
  - lost<=0, p<=1, go to HIGH.
- Timeout: in HIGH or LOW, when p reaches TIMEOUT without the awaited edge:
  - lost<=1, go to ARM.
  - high_cnt/period_cnt hold their last values; valid is not asserted.
- WAIT_RISE has no timeout; lost keeps its value there.
- valid is high for exactly one cycle per completed period; never on back-to-back cycles.
- Simultaneous timeout and edge in the same cycle: the edge wins (p==TIMEOUT-1 plus edge is a normal transition).
- Minimum measurable high/low phase is 1 cycle after synchronisation. Shorter glitches are filtered by the synchroniser sampling.
- Reset mid-measurement: immediate return to ARM with outputs zeroed; the next valid comes only after one full discarded partial period plus one complete period.
- All comparisons are unsigned, CNT_W bits wide.

Decomposition:
- Shared package pwm_pkg:
  - state enum {ARM, WAIT_RISE, HIGH, LOW}
  - CLK_PER_MS=100000, SERVO_PERIOD=2000000, SERVO_MIN=100000, SERVO_MAX=200000
  - These constants are also used by the generator's default parameters.
- One sub-module: sync_edge_det (2-flop synchroniser + rise/fall pulse outputs, async active-low reset), reusable for other pin inputs.

Test Plan:
- Nominal: 200000 high / 2000000 period, 3 periods -> valid twice; high_cnt=200000, period_cnt=2000000, range_err=0, lost=0.
- Minimum servo pulse: 100000/2000000 -> high_cnt=100000, period_cnt=2000000, range_err=0. Then 300000/2000000 -> range_err=1, high_cnt=300000.
- pwm_in held high across reset release, then normal 200000/2000000 -> no valid before the first low->high after a low phase; first valid reports exact values.
- Loss: with TIMEOUT=1000 override, stop toggling (hold low) -> lost=1 exactly 1000 cycles after the last rise counted by p; outputs hold. Resume pulses -> lost=0 with the next valid.
- Reset mid-HIGH: assert res for 3 cycles during a high phase -> all outputs 0 immediately (asynchronous); the first subsequent valid is at the end of the second full period after release.
- Short pulses: 5-cycle high / 20-cycle period -> high_cnt=5, period_cnt=20, range_err=1 with default MIN_HIGH.
